// File: rtl/priority_dec.sv
// Registered index-to-one-hot decoder with valid/ready handshake and a two-entry
// elastic buffer (output + skid). Optional per-entry range error via PRIORITY_DEC_ERR_EN.
module priority_dec #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] Y,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] D,
  output logic         valid,
  input  logic         out_ready
`ifdef PRIORITY_DEC_ERR_EN
  ,
  output logic         err
`endif
);

`ifdef PRIORITY_DEC_ERR_EN
  typedef struct packed {
    logic [N-1:0] onehot;
    logic         err;
  } entry_t;
`else
  typedef struct packed {
    logic [N-1:0] onehot;
  } entry_t;
`endif

  // Index 0 maps to the MSB so this block exactly inverts priority_enc.
  function automatic entry_t decode(input logic [W-1:0] idx);
    entry_t e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (32'(idx) == i) e.onehot[N-1-i] = 1'b1;
    end
`ifdef PRIORITY_DEC_ERR_EN
    e.err = (32'(idx) >= N);
`endif
    return e;
  endfunction

  entry_t out_q,  out_nxt;
  entry_t skid_q, skid_nxt;
  logic   out_full_q,  out_full_nxt;
  logic   skid_full_q, skid_full_nxt;

  logic accept;
  logic xfer;
  logic out_load;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign in_ready = ~skid_full_q;
  assign valid    = out_full_q;
  assign D        = out_q.onehot;
`ifdef PRIORITY_DEC_ERR_EN
  assign err      = out_q.err;
`endif

  assign accept   = in_valid & in_ready;
  assign xfer     = out_full_q & out_ready;
  assign out_load = ~out_full_q | xfer;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    out_nxt       = out_q;
    out_full_nxt  = out_full_q;
    skid_nxt      = skid_q;
    skid_full_nxt = skid_full_q;
    if (out_load) begin
      if (skid_full_q) begin
        // Skid drains first to keep FIFO order; accept is impossible here.
        out_nxt       = skid_q;
        out_full_nxt  = 1'b1;
        skid_nxt      = '0;
        skid_full_nxt = 1'b0;
      end else if (accept) begin
        out_nxt      = decode(Y);
        out_full_nxt = 1'b1;
      end else begin
        out_nxt      = '0;
        out_full_nxt = 1'b0;
      end
    end else if (accept) begin
      skid_nxt      = decode(Y);
      skid_full_nxt = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      out_full_q  <= 1'b0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
    end else begin
      out_q       <= out_nxt;
      out_full_q  <= out_full_nxt;
      skid_q      <= skid_nxt;
      skid_full_q <= skid_full_nxt;
    end
  end

`ifndef SYNTHESIS
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (valid && !out_ready) |=> (valid && $stable(D)));
  a_skid_implies_out: assert property (@(posedge clk) disable iff (!rst)
    skid_full_q |-> out_full_q);
  a_onehot: assert property (@(posedge clk) disable iff (!rst)
    valid |-> $onehot0(D));
`endif

endmodule

// File: tb/tb_priority_dec.sv
// Scoreboard bench for priority_dec: driver pushes expected one-hot values on accept,
// a monitor pops and compares on every output transfer.
module tb_priority_dec;
  logic       clk;
  logic       rst;
  logic [1:0] Y;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] D;
  logic       valid;
  logic       out_ready;
`ifdef PRIORITY_DEC_ERR_EN
  logic       err;
  logic [1:0] y3;
  logic       iv3, ir3, v3, e3;
  logic [2:0] d3;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int pop_cnt   = 0;
  int stall_cnt = 0;
  logic [3:0] sb[$];

  priority_dec #(.N(4)) dut (
    .clk(clk), .rst(rst), .Y(Y), .in_valid(in_valid), .in_ready(in_ready),
    .D(D), .valid(valid), .out_ready(out_ready)
`ifdef PRIORITY_DEC_ERR_EN
    , .err(err)
`endif
  );

`ifdef PRIORITY_DEC_ERR_EN
  priority_dec #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .Y(y3), .in_valid(iv3), .in_ready(ir3),
    .D(d3), .valid(v3), .out_ready(1'b1), .err(e3)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && valid === 1'b1 && out_ready === 1'b1) begin
      pop_cnt++;
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_out: got D=%b expected no output at %0t", D, $time);
      end else begin
        check("sb_D", 32'(D), 32'(sb.pop_front()));
`ifdef PRIORITY_DEC_ERR_EN
        check("sb_err", 32'(err), 32'(0));
`endif
      end
    end
  end

  task automatic send(input logic [1:0] y, input logic [3:0] exp);
    int n = 0;
    in_valid = 1'b1;
    Y        = y;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      stall_cnt++;
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for Y=%0d", y);
    end else begin
      sb.push_back(exp);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 check("drain_empty", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    int p0;
    rst = 1'b1; Y = '0; in_valid = 1'b0; out_ready = 1'b1;
`ifdef PRIORITY_DEC_ERR_EN
    y3 = '0; iv3 = 1'b0;
`endif
    #1 rst = 1'b0;
    #1;
    check("rst_D", 32'(D), 32'(4'b0000));
    check("rst_valid", 32'(valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Streaming at full rate
    p0 = pop_cnt;
    stall_cnt = 0;
    send(2'd0, 4'b1000);
    send(2'd1, 4'b0100);
    send(2'd2, 4'b0010);
    send(2'd3, 4'b0001);
    @(posedge clk);
    #1;
    check("stream_pops", 32'(pop_cnt - p0), 32'(4));
    check("stream_no_stall", 32'(stall_cnt), 32'(0));
    drain();

    // Backpressure: fill output and skid, then present a changing Y while stalled
    out_ready = 1'b0;
    send(2'd2, 4'b0010);
    send(2'd1, 4'b0100);
    check("bp_in_ready", 32'(in_ready), 32'(0));
    check("bp_valid", 32'(valid), 32'(1));
    check("bp_D", 32'(D), 32'(4'b0010));
    in_valid = 1'b1;
    Y        = 2'd0;
    repeat (2) @(posedge clk);
    #1 Y = 2'd3;
    @(posedge clk);
    #1 check("bp_hold_D", 32'(D), 32'(4'b0010));
    out_ready = 1'b1;
    send(2'd3, 4'b0001);
    check("bp_in_ready_back", 32'(in_ready), 32'(1));
    drain();

    // Alternating backpressure
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          @(posedge clk);
          #1 out_ready = ~out_ready;
        end
      end
      begin
        send(2'd3, 4'b0001);
        send(2'd0, 4'b1000);
        send(2'd1, 4'b0100);
        send(2'd2, 4'b0010);
        send(2'd3, 4'b0001);
        send(2'd0, 4'b1000);
        send(2'd1, 4'b0100);
        send(2'd2, 4'b0010);
      end
    join
    drain();

    // Asynchronous reset with two entries held
    out_ready = 1'b0;
    send(2'd0, 4'b1000);
    send(2'd1, 4'b0100);
    #2 rst = 1'b0;
    #1;
    check("midrst_D", 32'(D), 32'(4'b0000));
    check("midrst_valid", 32'(valid), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("post_rst_idle", 32'(valid), 32'(0));

`ifdef PRIORITY_DEC_ERR_EN
    // N=3 instance: out-of-range index
    iv3 = 1'b1; y3 = 2'd3;
    @(posedge clk);
    #1 iv3 = 1'b1; y3 = 2'd0;
    @(negedge clk);
    check("err_D", 32'(d3), 32'(3'b000));
    check("err_valid", 32'(v3), 32'(1));
    check("err_flag", 32'(e3), 32'(1));
    @(posedge clk);
    #1 iv3 = 1'b0;
    @(negedge clk);
    check("err_next_D", 32'(d3), 32'(3'b100));
    check("err_next_flag", 32'(e3), 32'(0));
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
